line_clear_ctrl: RTL and testbench

//  Sequences the line-clear / row-collapse pass on the playfield row store after a piece locks.

---
 rtl/line_clear_ctrl.sv | 162 ++++++++++++++++
 tb/tb_line_clear_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl
// Runs one line-clear pass over the playfield row store after a piece locks.
// Rows are scanned bottom to top. Full rows are dropped, and surviving rows are
// compacted downward in place. The vacated top rows are then written with zeros.
// The block reports the lines cleared in the pass and keeps a saturating total.
module line_clear_ctrl #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int TOT_W = 16,
  parameter int AW    = $clog2(ROWS),
  parameter int CW    = $clog2(ROWS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AW-1:0]    rd_addr,
  input  logic [COLS-1:0]  rd_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [COLS-1:0]  wr_data,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    lines_cleared,
  output logic [TOT_W-1:0] total_lines,
  input  logic             clr_total
);

  localparam int SW = TOT_W + CW;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [AW-1:0]   r;
  logic [CW-1:0]   w;
  logic [CW-1:0]   cnt;

  logic            row_full;
  logic            row_in_place;
  logic [CW-1:0]   cnt_next;
  logic [SW-1:0]   total_sum;
  logic [TOT_W-1:0] total_sat;

  // Classify the row being checked and precompute the saturated total.
  always_comb begin
    row_full     = &rd_data;
    row_in_place = (w == CW'(r));
    if (row_full) begin
      cnt_next = cnt + CW'(1);
    end else begin
      cnt_next = cnt;
    end
    total_sum = SW'(total_lines) + SW'(cnt);
    if (total_sum > SW'({TOT_W{1'b1}})) begin
      total_sat = {TOT_W{1'b1}};
    end else begin
      total_sat = total_sum[TOT_W-1:0];
    end
  end

  // Row-store write port: a moved row is written in the same cycle its read data
  // arrives (so it cannot collide with a later FILL write); FILL writes zeros.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = w[AW-1:0];
    wr_data = '0;
    case (state)
      ST_CHECK: begin
        if (!row_full && !row_in_place) begin
          wr_en   = 1'b1;
          wr_data = rd_data;
        end else begin
          wr_en   = 1'b0;
        end
      end
      ST_FILL: begin
        wr_en = 1'b1;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Pass sequencer: scan pointers, cleared-row count, status and totals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      r             <= '0;
      w             <= '0;
      cnt           <= '0;
      rd_addr       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            r       <= '0;
            w       <= '0;
            cnt     <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (row_full) begin
            cnt <= cnt_next;
          end else begin
            w <= w + CW'(1);
          end
          if (r == AW'(ROWS - 1)) begin
            if (cnt_next != '0) begin
              state <= ST_FILL;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else begin
            r       <= r + AW'(1);
            rd_addr <= r + AW'(1);
            state   <= ST_READ;
          end
        end
        ST_FILL: begin
          w <= w + CW'(1);
          if (w == CW'(ROWS - 1)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          lines_cleared <= cnt;
          total_lines   <= total_sat;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
      // A new game clears the total even if a pass completes on the same edge.
      if (clr_total) begin
        total_lines <= '0;
      end
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl with a registered-read row-store model
// and a scoreboard of expected pass results.
module tb_line_clear_ctrl;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int TOT_W = 8;
  localparam int AW    = $clog2(ROWS);
  localparam int CW    = $clog2(ROWS + 1);
  localparam int TMAX  = (1 << TOT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [AW-1:0]    rd_addr;
  logic [COLS-1:0]  rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [COLS-1:0]  wr_data;
  logic             busy;
  logic             done;
  logic [CW-1:0]    lines_cleared;
  logic [TOT_W-1:0] total_lines;
  logic             clr_total;

  logic [COLS-1:0]  mem [0:ROWS-1];
  logic [COLS-1:0]  init_rows [0:ROWS-1];
  logic             load_req;

  typedef struct {
    int                     cycles;
    int                     cleared;
    int                     total;
    logic [ROWS*COLS-1:0]   rows;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   model_total = 0;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .TOT_W(TOT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .total_lines(total_lines), .clr_total(clr_total)
  );

  always #5 clk = ~clk;

  // Row store: registered read, synchronous write, bench-side bulk load.
  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (load_req) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= init_rows[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Writes must never happen while the block is idle.
  always @(negedge clk) begin
    if (!reset && wr_en && !busy) check("wr_idle", 256'(wr_en), 256'(0));
  end

  function automatic logic [ROWS*COLS-1:0] mem_flat();
    logic [ROWS*COLS-1:0] f;
    for (int i = 0; i < ROWS; i++) f[i*COLS +: COLS] = mem[i];
    return f;
  endfunction

  task automatic load(input logic [ROWS*COLS-1:0] p);
    @(negedge clk);
    for (int i = 0; i < ROWS; i++) init_rows[i] = p[i*COLS +: COLS];
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic push_expect(input logic [ROWS*COLS-1:0] p, input bit clr);
    exp_t e;
    int   j;
    logic [COLS-1:0] row;
    e.cleared = 0;
    e.rows = '0;
    j = 0;
    for (int i = 0; i < ROWS; i++) begin
      row = p[i*COLS +: COLS];
      if (row == {COLS{1'b1}}) begin
        e.cleared++;
      end else begin
        e.rows[j*COLS +: COLS] = row;
        j++;
      end
    end
    e.cycles = 2 * ROWS + e.cleared + 1;
    if (clr) model_total = 0;
    else if (model_total + e.cleared > TMAX) model_total = TMAX;
    else model_total = model_total + e.cleared;
    e.total = model_total;
    sb.push_back(e);
  endtask

  task automatic run_pass(input string name, input logic [ROWS*COLS-1:0] p,
                          input bit clr, input bit extra);
    exp_t e;
    int   k;
    load(p);
    push_expect(p, clr);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      start = extra && (k == 5 || k == 12);
      if (done || k > 200) break;
    end
    start     = extra;
    clr_total = clr;
    e = sb.pop_front();
    check({name, "_done_cycle"}, 256'(k), 256'(e.cycles));
    @(negedge clk);
    start     = 1'b0;
    clr_total = 1'b0;
    check({name, "_cleared"}, 256'(lines_cleared), 256'(e.cleared));
    check({name, "_total"}, 256'(total_lines), 256'(e.total));
    check({name, "_idle"}, 256'({busy, done}), 256'(0));
    check({name, "_rows"}, 256'(mem_flat()), 256'(e.rows));
  endtask

  initial begin
    logic [ROWS*COLS-1:0] p;
    logic [COLS-1:0]      row;
    int                   k;
    reset = 1'b1; start = 1'b0; clr_total = 1'b0; load_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", 256'({busy, done, wr_en, rd_addr, wr_addr, wr_data}), 256'(0));
    check("rst_counts", 256'({lines_cleared, total_lines}), 256'(0));
    reset = 1'b0;

    // No full rows, rows 0-4 partial.
    p = '0;
    for (int i = 0; i < 5; i++) p[i*COLS +: COLS] = COLS'(10'h011 + i);
    run_pass("nofull", p, 1'b0, 1'b1);

    // Row 0 full, row 1 = 001.
    p = '0; p[0 +: COLS] = '1; p[COLS +: COLS] = 10'h001;
    run_pass("row0", p, 1'b0, 1'b0);

    // Rows 0-3 full, row 4 = 155.
    p = '0;
    for (int i = 0; i < 4; i++) p[i*COLS +: COLS] = '1;
    p[4*COLS +: COLS] = 10'h155;
    run_pass("four", p, 1'b0, 1'b0);

    // Rows 1 and 3 full between A, B, C.
    p = '0;
    p[0 +: COLS] = 10'h2A1; p[COLS +: COLS] = '1; p[2*COLS +: COLS] = 10'h0F0;
    p[3*COLS +: COLS] = '1; p[4*COLS +: COLS] = 10'h30C;
    run_pass("split", p, 1'b0, 1'b1);

    // Random mixes of full and partial rows.
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < ROWS; i++) begin
        row = ($urandom_range(0, 2) == 0) ? {COLS{1'b1}} : COLS'($urandom_range(0, 1022));
        p[i*COLS +: COLS] = row;
      end
      run_pass("rand", p, 1'b0, 1'b0);
    end

    // Reset in the CHECK cycle of row 7 with start pulses while busy.
    p = '0;
    for (int i = 0; i < ROWS; i += 2) p[i*COLS +: COLS] = '1;
    load(p);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (k < 16) begin
      @(negedge clk);
      k++;
      start = (k == 3 || k == 9);
    end
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("midrst_outs", 256'({busy, done, wr_en, rd_addr, wr_addr}), 256'(0));
    check("midrst_counts", 256'({lines_cleared, total_lines}), 256'(0));
    model_total = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_idle", 256'(busy), 256'(0));
    p = '0;
    for (int i = 0; i < 4; i++) p[i*COLS +: COLS] = '1;
    p[4*COLS +: COLS] = 10'h155;
    run_pass("postrst", p, 1'b0, 1'b0);

    // Accumulate toward saturation with all-full passes.
    p = '1;
    for (int n = 0; n < 12; n++) run_pass("allfull", p, 1'b0, 1'b0);

    // Bring the total to max-1 exactly.
    p = '0;
    for (int i = 0; i < TMAX - 1 - model_total; i++) p[i*COLS +: COLS] = '1;
    p[(ROWS-1)*COLS +: COLS] = 10'h001;
    run_pass("near_max", p, 1'b0, 1'b0);

    // Three-line pass saturates at the maximum.
    p = '0;
    p[2*COLS +: COLS] = '1; p[5*COLS +: COLS] = '1; p[9*COLS +: COLS] = '1;
    p[0 +: COLS] = 10'h0C3; p[7*COLS +: COLS] = 10'h300;
    run_pass("saturate", p, 1'b0, 1'b0);

    // New-game clear coincident with done wins over the update.
    run_pass("clr_at_done", p, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
